// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared constants for serial datapath controllers.
//   state_t : sequencer state encoding (IDLE / RUN / DONE)
//   NIB_W   : width of one datapath slice (a nibble)
package nibble_serial_adder_ctrl_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fourbitadder.sv
// 4-bit ripple adder cell reused by the serial sequencer.
// Ports:
//   carry_out : carry out of bit 3
//   sum       : 4-bit sum a + b + cin (mod 16)
//   a, b      : 4-bit operands
//   cin       : carry in to bit 0
module fourbitadder
   import nibble_serial_adder_ctrl_pkg::*;
(
   output logic             carry_out,
   output logic [NIB_W-1:0] sum,
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             cin
);

   logic [NIB_W:0] total_s;

   assign total_s   = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
   assign sum       = total_s[NIB_W-1:0];
   assign carry_out = total_s[NIB_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder: one fourbitadder is reused over WIDTH/4 cycles,
// least-significant nibble first, with the nibble carry held in a register.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   a, b, cin            : operands and carry into nibble 0
//   out_valid / out_ready: result handshake (out_valid high only in DONE)
//   sum, cout, ovf       : result, carry out of MSB, signed overflow
//   busy                 : high while nibbles are being processed
module nibble_serial_adder_ctrl
   import nibble_serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int NIBS  = WIDTH / NIB_W;
   localparam int CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;

   generate
      if (((WIDTH % NIB_W) != 0) || (WIDTH < 8)) begin : g_width_check
         $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 8");
      end
   endgenerate

   state_t             state_r;
   state_t             state_s;
   logic [WIDTH-1:0]   a_sh_r;
   logic [WIDTH-1:0]   b_sh_r;
   logic [WIDTH-1:0]   sum_r;
   logic               carry_r;
   logic               a_msb_r;
   logic               b_msb_r;
   logic               cout_r;
   logic               ovf_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [NIB_W-1:0]   nib_sum_s;
   logic               nib_carry_s;
   logic               last_s;

   // The single shared adder slice always looks at the low nibble of the shifters.
   fourbitadder u_adder (
      .carry_out (nib_carry_s),
      .sum       (nib_sum_s),
      .a         (a_sh_r[NIB_W-1:0]),
      .b         (b_sh_r[NIB_W-1:0]),
      .cin       (carry_r)
   );

   assign last_s = (state_r == RUN) && (cnt_r == CNT_W'(NIBS - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_s = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               state_s = DONE;
            end else begin
               state_s = RUN;
            end
         end
         DONE: begin
            // Leaving DONE always passes through IDLE, so there is no same-cycle re-accept.
            if (out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Operand shifters, nibble carry, counter and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh_r  <= '0;
         b_sh_r  <= '0;
         sum_r   <= '0;
         carry_r <= 1'b0;
         a_msb_r <= 1'b0;
         b_msb_r <= 1'b0;
         cout_r  <= 1'b0;
         ovf_r   <= 1'b0;
         cnt_r   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  a_sh_r  <= a;
                  b_sh_r  <= b;
                  // Reloaded on every accept so no carry leaks from the previous add.
                  carry_r <= cin;
                  a_msb_r <= a[WIDTH-1];
                  b_msb_r <= b[WIDTH-1];
                  cnt_r   <= '0;
               end
            end
            RUN: begin
               // Nibble sums enter from the top so nibble 0 ends up at the bottom after NIBS steps.
               sum_r   <= {nib_sum_s, sum_r[WIDTH-1:NIB_W]};
               a_sh_r  <= {{NIB_W{1'b0}}, a_sh_r[WIDTH-1:NIB_W]};
               b_sh_r  <= {{NIB_W{1'b0}}, b_sh_r[WIDTH-1:NIB_W]};
               carry_r <= nib_carry_s;
               cnt_r   <= cnt_r + CNT_W'(1);
               if (last_s) begin
                  cout_r <= nib_carry_s;
                  // Same-sign operands giving a different-sign result overflow.
                  ovf_r  <= (a_msb_r == b_msb_r) && (nib_sum_s[NIB_W-1] != a_msb_r);
               end
            end
            DONE: begin
               sum_r  <= sum_r;
               cout_r <= cout_r;
               ovf_r  <= ovf_r;
            end
            default: begin
               cnt_r <= '0;
            end
         endcase
      end
   end

   assign in_ready  = (state_r == IDLE);
   assign busy      = (state_r == RUN);
   assign out_valid = (state_r == DONE);
   assign sum       = sum_r;
   assign cout      = cout_r;
   assign ovf       = ovf_r;

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that computes a WIDTH-bit add by time-multiplexing one fourbitadder instance over WIDTH/4 cycles, least-significant nibble first.
- The nibble carry is held in a register between cycles.
- Operands enter through a valid/ready handshake; the result leaves through a valid/ready handshake.
- It is the area-saving alternative to a full-width ripple adder: a wide add built from the existing 4-bit adder cell.

Parameters:
WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 8; violating this is an elaboration error.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands a, b, cin are presented
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry into nibble 0
out_valid  output  1  sum/cout/ovf are valid (high only in DONE)
out_ready  input  1  consumer accepts result
sum  output  WIDTH  a + b + cin, modulo 2^WIDTH
cout  output  1  carry out of the MSB nibble
ovf  output  1  signed (two's-complement) overflow
busy  output  1  high in RUN

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at an edge):
  - state <= IDLE; sum, cout, ovf, out_valid, busy and the internal nibble counter <= 0.
  - rst overrides every other input in the same cycle.
- Outputs are decoded from the state: in_ready = (state==IDLE), busy = (state==RUN), out_valid = (state==DONE).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On in_valid && in_ready at an edge:
    - a_sh <= a and b_sh <= b (shift registers); carry_q <= cin; cnt <= 0.
    - a_msb <= a[WIDTH-1] and b_msb <= b[WIDTH-1].
    - Go to RUN.
  - in_valid low: remain in IDLE.
- RUN, each cycle:
  - The adder sees a_sh[3:0], b_sh[3:0] and carry_q.
  - The nibble sum shifts into sum from the top: sum <= {nib_sum, sum[WIDTH-1:4]}.
  - a_sh and b_sh shift right by 4; carry_q <= nibble carry; cnt <= cnt+1.
  - When cnt == WIDTH/4-1: cout <= nibble carry, ovf <= (a_msb==b_msb) && (nib_sum[3]!=a_msb), go to DONE.
- DONE:
  - sum, cout and ovf are held stable.
  - On out_ready: go to IDLE. in_ready rises the next cycle; there is no same-cycle re-accept.
  - out_ready low: hold indefinitely (backpressure).
- Latency: operands accepted at edge k → out_valid high after edge k+WIDTH/4 (4 cycles for WIDTH=16). Throughput is one add per WIDTH/4+2 cycles minimum.
- in_valid while busy or in DONE: ignored, and operands are not sampled. in_valid must be held until accepted.
- a, b and cin may change freely after acceptance; the result depends only on the sampled values.
- out_ready outside DONE: ignored.
- Reset mid-RUN or mid-DONE: the operation is aborted and no out_valid pulse occurs. The next accepted operation is unaffected.
- sum is undefined-but-deterministic during RUN (partial shifts). Consumers sample it only on out_valid.
- Carry wrap: the final carry never feeds back into nibble 0 of the next operation; carry_q is reloaded from cin on each acceptance.

Decomposition:
- Shared constants header: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and nibble width 4. It is shared with future serial datapath controllers.
- One sub-module: the existing fourbitadder, instantiated once with port order (carry_out, sum, a, b, cin).
- All sequencing, the counter and the shift registers live in nibble_serial_adder_ctrl.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0, ovf=0; out_valid rises exactly 4 cycles after acceptance.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. This checks carry propagation through all 4 nibble steps via carry_q.
- a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1. Then a=0xFFFF, b=0xFFFF, cin=1 → sum=0xFFFF, cout=1, ovf=0.
- Backpressure:
  - Hold out_ready=0 for 6 cycles in DONE while driving in_valid with new operands → sum/cout/ovf stable, in_ready=0, new operands are not taken.
  - Then out_ready=1 for one cycle → IDLE, and the pending operands are accepted on the following edge.
- Assert rst for one cycle during RUN (cnt=2) → out_valid never asserts for that operation, state returns to IDLE, all outputs are 0. The next add, 0x00FF+0x0001, gives 0x0100.
- Exhaustive check with WIDTH=8: all 256×256×2 input combinations, back-to-back with out_ready=1 → every result matches a+b+cin, with correct cout and ovf.
